// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; InstrF registered to InstrD one cycle after PCF presents it.
// Latency: 1 cycle PCF->InstrD, redirect target on PCF next cycle; stalls hold PC/D, flush bubbles D.
// Optional FETCH_STATS_EN adds saturating fetch/flush counters (tied to 0 when undefined).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignErr,
    output logic [31:0] FetchCount,
    output logic [15:0] FlushCount
);

    logic [31:0] pcplus4f;
    logic        load_d;

    assign pcplus4f = PCF + 32'd4;
    assign load_d   = !FlushD && !StallD;

    always_ff @(posedge clk) begin
        if (!rst) begin
            PCF         <= RESET_PC;
            InstrD      <= NOP_INSTR;
            PCD         <= 32'd0;
            PCPlus4D    <= 32'd0;
            ValidD      <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            // Redirect wins over StallF; low bits are forced to word alignment.
            if (PCSrcE) begin
                PCF <= {PCTargetE[31:2], 2'b00};
            end else if (!StallF) begin
                PCF <= pcplus4f;
            end

            if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
                MisalignErr <= 1'b1;
            end

            if (FlushD) begin
                InstrD   <= NOP_INSTR;
                PCD      <= 32'd0;
                PCPlus4D <= 32'd0;
                ValidD   <= 1'b0;
            end else if (!StallD) begin
                InstrD   <= InstrF;
                PCD      <= PCF;
                PCPlus4D <= pcplus4f;
                ValidD   <= 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            FetchCount <= 32'd0;
            FlushCount <= 16'd0;
        end else begin
            if (load_d && (FetchCount != 32'hFFFF_FFFF)) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (FlushD && (FlushCount != 16'hFFFF)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`else
    logic unused_load;
    assign unused_load = load_d;
    assign FetchCount  = 32'd0;
    assign FlushCount  = 16'd0;
`endif

endmodule
